// File: rtl/yoda_encoder.sv
// Run-length encoder for the YODA decoder: raw bytes in, (count, value) pairs out,
// closed by a 0x00 terminator. Ready/ack handshakes match the decoder side.
module yoda_encoder #(
    parameter int unsigned MAX_RUN = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rd,
    input  logic [7:0] data_in,
    input  logic       last,
    output logic       reading,
    output logic [7:0] data_out,
    output logic       sending,
    input  logic       received,
    output logic       done
);

    localparam logic [7:0] RUN_LIMIT = 8'(MAX_RUN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT_CNT,
        S_GAP_CNT,
        S_EMIT_VAL,
        S_GAP_VAL,
        S_EMIT_TERM,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] value, count, pend;
    logic       pend_last, pend_v, closed, reading_q;
    logic       capture, extend;

    // One capture per two cycles: the reading pulse blocks the cycle after a capture.
    assign capture = ((state == S_IDLE) || (state == S_ACCUM)) && rd && !reading_q;
    assign extend  = (data_in == value) && (count < RUN_LIMIT);
    assign reading = reading_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sending   = 1'b0;
        data_out  = '0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (capture) state_nxt = last ? S_EMIT_CNT : S_ACCUM;
            end
            S_ACCUM: begin
                if (capture) begin
                    if (extend) state_nxt = last ? S_EMIT_CNT : S_ACCUM;
                    else        state_nxt = S_EMIT_CNT;
                end
            end
            S_EMIT_CNT: begin
                sending  = 1'b1;
                data_out = count;
                if (received) state_nxt = S_GAP_CNT;
            end
            S_GAP_CNT: begin
                state_nxt = S_EMIT_VAL;
            end
            S_EMIT_VAL: begin
                sending  = 1'b1;
                data_out = value;
                if (received) state_nxt = S_GAP_VAL;
            end
            S_GAP_VAL: begin
                if (pend_v)      state_nxt = pend_last ? S_EMIT_CNT : S_ACCUM;
                else if (closed) state_nxt = S_EMIT_TERM;
                else             state_nxt = S_ACCUM;
            end
            S_EMIT_TERM: begin
                sending = 1'b1;
                if (received) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value     <= '0;
            count     <= '0;
            pend      <= '0;
            pend_last <= 1'b0;
            pend_v    <= 1'b0;
            closed    <= 1'b0;
            reading_q <= 1'b0;
        end else begin
            reading_q <= capture;
            if (capture) begin
                if (last) closed <= 1'b1;
                if (state == S_IDLE) begin
                    value <= data_in;
                    count <= 8'd1;
                end else if (extend) begin
                    count <= count + 8'd1;
                end else begin
                    // Byte that breaks the run waits here while the closed run is emitted.
                    pend      <= data_in;
                    pend_last <= last;
                    pend_v    <= 1'b1;
                end
            end
            if ((state == S_GAP_VAL) && pend_v) begin
                value     <= pend;
                count     <= 8'd1;
                pend_v    <= 1'b0;
                pend_last <= 1'b0;
            end
        end
    end

endmodule
